// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin index arbiter.
package arb_pkg;

  localparam int N_REQ_DEF = 8;
  localparam int IDX_W_DEF = 3;

  typedef enum logic {
    IDLE,
    OFFER
  } arb_state_t;

  // Modular increment of a requester index.
  function automatic logic [31:0] idx_wrap(input logic [31:0] i, input logic [31:0] n);
    return (i + 32'd1) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate by ptr, fixed-priority encode, un-rotate.
module rr_pick #(
  parameter int N_REQ = 8,
  parameter int IDX_W = 3
) (
  input  logic [N_REQ-1:0] mask,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] pick
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] off;

  always_comb begin
    rot = '0;
    sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel    = IDX_W'(i) + ptr;
      rot[i] = mask[sel];
    end
  end

  // Lowest set bit of the rotated mask is the first requester at or after ptr.
  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  assign pick = off + ptr;
  assign any  = |mask;

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter presenting the winner as a registered index with valid/ready.
// Optional burst ownership via the lock input when RR_LOCK_EN is defined.
module rr_index_arbiter
  import arb_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  input  logic             idx_ready
`ifdef RR_LOCK_EN
  ,
  input  logic             lock
`endif
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_p0, idx_d;
  logic             vld_p0, vld_d;
  logic [N_REQ-1:0] mask;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] pick;
  logic             any;
  logic             hs;
  logic             hold;

`ifdef RR_LOCK_EN
  assign hold = lock;
`else
  assign hold = 1'b0;
`endif

  assign hs = vld_p0 & idx_ready;

  // The granted requester still shows req in the handshake cycle, so it is
  // masked out unless ownership is held, in which case the search restarts at it.
  always_comb begin
    mask = req;
    base = ptr_q;
    if (state_q == OFFER && hs) begin
      if (hold) begin
        base = idx_p0;
      end else begin
        base = IDX_W'(idx_wrap(32'(idx_p0), N_REQ));
        mask = req & ~(N_REQ'(1) << idx_p0);
      end
    end
  end

  rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .mask(mask),
    .ptr (base),
    .any (any),
    .pick(pick)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_p0;
    vld_d   = vld_p0;
    case (state_q)
      IDLE: begin
        if (en && any) begin
          idx_d   = pick;
          vld_d   = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (hs) begin
          if (!hold) ptr_d = base;
          if (en && any) begin
            idx_d = pick;
          end else begin
            vld_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_p0  <= '0;
      vld_p0  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_p0  <= idx_d;
      vld_p0  <= vld_d;
    end
  end

  assign idx       = idx_p0;
  assign idx_valid = vld_p0;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Self-checking bench for rr_index_arbiter: directed steps then randomized traffic
// against a behavioural reference model.
module tb_rr_index_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [N-1:0] req;
  logic [2:0]   idx;
  logic         idx_valid;
  logic         idx_ready;
  logic         lock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_v;
  int m_idx;
  int m_ptr;

  always #5 clk = ~clk;

  rr_index_arbiter #(.N_REQ(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .idx      (idx),
    .idx_valid(idx_valid),
    .idx_ready(idx_ready)
`ifdef RR_LOCK_EN
    ,
    .lock     (lock)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // First set bit of m searching upward from base, wrapping.
  function automatic int search(input logic [N-1:0] m, input int base);
    for (int k = 0; k < N; k++) begin
      if (m[(base + k) % N]) return (base + k) % N;
    end
    return 0;
  endfunction

  // One clock: advance the model from the inputs held across the edge, then compare.
  task automatic tick();
    bit           nv;
    int           ni, np, b;
    bit           lk;
    logic [N-1:0] m;
    nv = m_v; ni = m_idx; np = m_ptr;
    lk = 1'b0;
`ifdef RR_LOCK_EN
    lk = lock;
`endif
    if (!rst_n) begin
      nv = 0; ni = 0; np = 0;
    end else if (!m_v) begin
      if (en && req != '0) begin
        ni = search(req, m_ptr);
        nv = 1;
      end
    end else if (idx_ready) begin
      if (lk) begin
        b = m_idx;
        m = req;
      end else begin
        b  = (m_idx + 1) % N;
        np = b;
        m  = req & ~(N'(1) << m_idx);
      end
      if (en && m != '0) ni = search(m, b);
      else nv = 0;
    end
    @(posedge clk);
    #1;
    m_v = nv; m_idx = ni; m_ptr = np;
    chk("model_vld", 32'(idx_valid), 32'(m_v));
    if (m_v) chk("model_idx", 32'(idx), 32'(m_idx));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; req = 8'hFF; idx_ready = 1'b0; lock = 1'b0;
    m_v = 0; m_idx = 0; m_ptr = 0;

    // Reset with all requesters active
    tick(); tick();
    chk("rst_idx", 32'(idx), 0);
    chk("rst_vld", 32'(idx_valid), 0);
    rst_n = 1'b1;
    tick();
    chk("rel_idx", 32'(idx), 0);
    chk("rel_vld", 32'(idx_valid), 1);

    // Round-robin sweep with constant ready
    idx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rr_idx", 32'(idx), 32'(k % 8));
      chk("rr_vld", 32'(idx_valid), 1);
    end

    // Backpressure: offer of 2 held, survives req drop, then 5
    req = 8'h24;
    tick();
    chk("bp_first", 32'(idx), 2);
    idx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) req = 8'h20;
      tick();
      chk("bp_hold", 32'(idx), 2);
      chk("bp_vld", 32'(idx_valid), 1);
    end
    idx_ready = 1'b1;
    tick();
    chk("bp_next", 32'(idx), 5);
    req = 8'h00;
    tick();
    chk("bp_idle", 32'(idx_valid), 0);

    // Wrap: after granting 6, requester 0 wins before 6 again
    req = 8'h40; idx_ready = 1'b0;
    tick();
    chk("wrap_g6", 32'(idx), 6);
    req = 8'h41; idx_ready = 1'b1;
    tick();
    chk("wrap_g0", 32'(idx), 0);
    tick();
    chk("wrap_g6b", 32'(idx), 6);
    req = 8'h00;
    tick();
    chk("wrap_idle", 32'(idx_valid), 0);

    // en low during an offer: completes, then stays idle until en returns
    req = 8'hFF; idx_ready = 1'b0;
    tick();
    chk("en_offer", 32'(idx), 7);
    en = 1'b0;
    tick();
    chk("en_hold", 32'(idx_valid), 1);
    idx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("en_off_vld", 32'(idx_valid), 0);
    end
    en = 1'b1; idx_ready = 1'b0;
    tick();
    chk("en_back_vld", 32'(idx_valid), 1);
    chk("en_back_idx", 32'(idx), 0);

    // Synchronous reset while offering
    rst_n = 1'b0;
    tick();
    chk("rst_offer_vld", 32'(idx_valid), 0);
    rst_n = 1'b1;
    req = 8'h00;
    tick();

`ifdef RR_LOCK_EN
    // Burst ownership: 0 re-offered while locked, then 3 after release
    req = 8'h09; lock = 1'b1; idx_ready = 1'b0;
    tick();
    chk("lock_g0", 32'(idx), 0);
    idx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("lock_re", 32'(idx), 0);
    end
    lock = 1'b0;
    tick();
    chk("lock_rel", 32'(idx), 3);
    req = 8'h00;
    tick();
`endif

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      req       = N'($urandom);
      en        = ($urandom_range(0, 7) != 0);
      idx_ready = ($urandom_range(0, 2) != 0);
      rst_n     = ($urandom_range(0, 49) != 0);
      lock      = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
